// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Optional EX_STATS_EN adds the stall_count / fwd_count performance counters.
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     hold,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alusrc,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     id_memwrite,
  input  logic                     mem_regwrite,
  input  logic [REG_ADDR-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic                     wb_regwrite,
  input  logic [REG_ADDR-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_regwrite,
  output logic                     ex_memread,
  output logic                     ex_memwrite,
`ifdef EX_STATS_EN
  output logic [31:0]              stall_count,
  output logic [31:0]              fwd_count,
`endif
  output logic [DATA_WIDTH-1:0]    ex_store_data
);

  logic                     valid_q, valid_d;
  logic [REG_ADDR-1:0]      rs1_q, rs1_d;
  logic [REG_ADDR-1:0]      rs2_q, rs2_d;
  logic [REG_ADDR-1:0]      rd_q, rd_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]    rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]    imm_q, imm_d;
  logic                     alusrc_q, alusrc_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic                     regwrite_q, regwrite_d;
  logic                     memread_q, memread_d;
  logic                     memwrite_q, memwrite_d;

  logic load_use;
  logic capture;
  logic kill;

  // rs2 only matters to a load-use check when it is actually read (register operand or store data).
  assign load_use = valid_q & memread_q & (rd_q != '0) & id_valid &
                    ((rd_q == id_rs1) | ((rd_q == id_rs2) & (!id_alusrc | id_memwrite)));

  assign id_ready = !hold & !load_use;
  assign capture  = !flush & !hold & !load_use & id_valid;
  assign kill     = flush | (!hold & !capture);

  always_comb begin
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    op_d       = op_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    if (kill) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else if (capture) begin
      valid_d    = 1'b1;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      op_d       = id_operation;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      op_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      op_q       <= op_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  logic [REG_ADDR-1:0]   src_rs  [2];
  logic [DATA_WIDTH-1:0] src_reg [2];
  logic [DATA_WIDTH-1:0] fwd_val [2];
  logic [1:0]            fwd_hit;

  assign src_rs[0]  = rs1_q;
  assign src_rs[1]  = rs2_q;
  assign src_reg[0] = rs1_data_q;
  assign src_reg[1] = rs2_data_q;

  // MEM is the younger producer, so it wins over WB; x0 is hardwired zero and never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit      = mem_regwrite & (mem_rd != '0) & (mem_rd == src_rs[gi]);
      assign wb_hit       = wb_regwrite & (wb_rd != '0) & (wb_rd == src_rs[gi]);
      assign fwd_hit[gi]  = mem_hit | wb_hit;
      assign fwd_val[gi]  = mem_hit ? mem_result : (wb_hit ? wb_result : src_reg[gi]);
    end
  endgenerate

  assign ex_valid      = valid_q;
  assign SrcA          = fwd_val[0];
  assign SrcB          = alusrc_q ? imm_q : fwd_val[1];
  assign ex_store_data = fwd_val[1];
  assign Operation     = op_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = valid_q & regwrite_q;
  assign ex_memread    = valid_q & memread_q;
  assign ex_memwrite   = valid_q & memwrite_q;

`ifdef EX_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_d   = stall_q;
    fwd_cnt_d = fwd_cnt_q;
    if (load_use && !hold) begin
      stall_d = stall_q + 32'd1;
    end
    if (valid_q && (fwd_hit != 2'b00)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q   <= '0;
      fwd_cnt_q <= '0;
    end else begin
      stall_q   <= stall_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign stall_count = stall_q;
  assign fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomised bench for ex_operand_stage: transaction-level model of the EX slot plus directed literal checks.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, hold, id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alusrc;
  logic [3:0]  id_operation;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
`ifdef EX_STATS_EN
  logic [31:0] stall_count, fwd_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_operation(id_operation),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite),
`ifdef EX_STATS_EN
    .stall_count(stall_count), .fwd_count(fwd_count),
`endif
    .ex_store_data(ex_store_data)
  );

  // The instruction currently sitting in EX, as the bench believes it to be.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alusrc;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } ex_t;

  ex_t         m;
  logic [31:0] m_stall, m_fwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // 0 = no forward, 1 = MEM, 2 = WB
  function automatic int src_of(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (mem_regwrite && mem_rd == rs) return 1;
    if (wb_regwrite && wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
    case (src_of(rs))
      1:       return mem_result;
      2:       return wb_result;
      default: return regval;
    endcase
  endfunction

  function automatic bit stall_now();
    bit reads;
    if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
    reads = (m.rd == id_rs1);
    if (m.rd == id_rs2 && (!id_alusrc || id_memwrite)) reads = 1'b1;
    return reads;
  endfunction

  always @(posedge clk or negedge reset) begin
    ex_t nx;
    if (!reset) begin
      m       <= '0;
      m_stall <= '0;
      m_fwd   <= '0;
    end else begin
      nx = m;
      if (flush || (!hold && (stall_now() || !id_valid))) begin
        nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
      end else if (!hold) begin
        nx = '{v:1'b1, rs1:id_rs1, rs2:id_rs2, rd:id_rd, d1:id_rs1_data, d2:id_rs2_data,
               imm:id_imm, alusrc:id_alusrc, op:id_operation,
               rw:id_regwrite, mr:id_memread, mw:id_memwrite};
      end
      if (stall_now() && !hold) m_stall <= m_stall + 1;
      if (m.v && (src_of(m.rs1) != 0 || src_of(m.rs2) != 0)) m_fwd <= m_fwd + 1;
      m <= nx;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("id_ready",   {31'd0, id_ready},    {31'd0, !hold && !stall_now()});
      chk("ex_valid",   {31'd0, ex_valid},    {31'd0, m.v});
      chk("SrcA",       SrcA,                 operand(m.rs1, m.d1));
      chk("SrcB",       SrcB,                 m.alusrc ? m.imm : operand(m.rs2, m.d2));
      chk("store_data", ex_store_data,        operand(m.rs2, m.d2));
      chk("Operation",  {28'd0, Operation},   {28'd0, m.op});
      chk("ex_rd",      {27'd0, ex_rd},       {27'd0, m.rd});
      chk("ex_ctrl",    {29'd0, ex_regwrite, ex_memread, ex_memwrite},
                        {29'd0, m.v & m.rw, m.v & m.mr, m.v & m.mw});
`ifdef EX_STATS_EN
      chk("stall_count", stall_count, m_stall);
      chk("fwd_count",   fwd_count,   m_fwd);
`endif
    end
  end

  task automatic idle();
    flush = 0; hold = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_alusrc = 0; id_operation = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    idle();
    repeat (2) step();
    #2;
    chk("rst_ex_valid",  {31'd0, ex_valid},  32'd0);
    chk("rst_Operation", {28'd0, Operation}, 32'd0);
    chk("rst_ex_rd",     {27'd0, ex_rd},     32'd0);
    chk("rst_regwrite",  {31'd0, ex_regwrite}, 32'd0);
    reset = 1;
    step();
    cmp_en = 1;

    // basic capture with immediate
    id_valid = 1; id_rs1 = 1; id_rd = 2; id_rs1_data = 5; id_imm = 7;
    id_alusrc = 1; id_operation = 4'b0010;
    step();
    id_valid = 0; hold = 1;
    #2;
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("cap_SrcA",  SrcA, 32'd5);
    chk("cap_SrcB",  SrcB, 32'd7);
    chk("cap_op",    {28'd0, Operation}, 32'h2);

    // MEM beats WB, then WB alone
    hold = 0; id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h11; id_alusrc = 0;
    step();
    hold = 1; id_valid = 0;
    mem_regwrite = 1; mem_rd = 3; mem_result = 32'hAA;
    wb_regwrite = 1; wb_rd = 3; wb_result = 32'hBB;
    #2;
    chk("fwd_mem_prio", SrcA, 32'hAA);
    mem_regwrite = 0;
    #1;
    chk("fwd_wb", SrcA, 32'hBB);

    // x0 is never forwarded
    hold = 0; wb_regwrite = 0; id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h33;
    step();
    hold = 1; id_valid = 0; wb_regwrite = 1; wb_rd = 0; wb_result = 32'hFF;
    #2;
    chk("fwd_x0", SrcA, 32'h33);

    // load-use: one bubble then capture
    idle();
    id_valid = 1; id_memread = 1; id_rd = 4; id_rs1 = 1;
    step();
    id_memread = 0; id_rd = 5; id_rs1 = 4; id_rs1_data = 32'h44;
    #2;
    chk("lu_ready", {31'd0, id_ready}, 32'd0);
    step();
    #2;
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_ready2", {31'd0, id_ready}, 32'd1);
    step();
    id_valid = 0;
    #2;
    chk("lu_capture", {31'd0, ex_valid}, 32'd1);
    chk("lu_rd",      {27'd0, ex_rd},    32'd5);

    // flush overrides hold
    flush = 1; hold = 1;
    step();
    flush = 0; hold = 0;
    #2;
    chk("flush_hold", {31'd0, ex_valid}, 32'd0);

`ifdef EX_STATS_EN
    idle();
    reset = 0;
    step();
    reset = 1;
    id_valid = 1; id_memread = 1; id_rd = 4; id_rs1 = 1;
    step();
    id_rs1 = 4;
    repeat (6) step();
    id_valid = 0;
    #2;
    chk("stall_3", stall_count, 32'd3);
`endif

    // asynchronous reset while holding
    idle();
    id_valid = 1; id_rs1 = 2; id_rd = 6;
    step();
    id_valid = 0; hold = 1;
    step();
    #2;
    chk("hold_valid", {31'd0, ex_valid}, 32'd1);
    reset = 0;
    #1;
    chk("async_rst", {31'd0, ex_valid}, 32'd0);
    step();
    reset = 1;
    hold = 0;

    // randomised traffic over a small register window so hazards are frequent
    for (int i = 0; i < 1500; i++) begin
      step();
      reset        = ($urandom_range(0, 99) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      hold         = ($urandom_range(0, 7) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_alusrc    = 1'($urandom_range(0, 1));
      id_operation = 4'($urandom);
      id_regwrite  = 1'($urandom_range(0, 1));
      id_memread   = ($urandom_range(0, 2) == 0);
      id_memwrite  = ($urandom_range(0, 3) == 0);
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 7));
      mem_result   = $urandom;
      wb_regwrite  = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 7));
      wb_result    = $urandom;
    end
    step();
    reset = 1;
    repeat (2) step();
    cmp_en = 0;
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU.
- Latches decoded operands and control from decode and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, stalls decode and inserts a bubble.
- Drives SrcA, SrcB and Operation straight into the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  kill the EX-stage contents (branch taken)
- hold  in  1  downstream stall; freeze the stage
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- id_rs1, id_rs2, id_rd  in  REG_ADDR  source and destination indices
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_alusrc  in  1  1 selects id_imm for SrcB
- id_operation  in  OPCODE_LENGTH  ALU operation code
- id_regwrite, id_memread, id_memwrite  in  1  control bits
- mem_regwrite  in  1  MEM-stage write enable
- mem_rd  in  REG_ADDR  MEM-stage destination
- mem_result  in  DATA_WIDTH  MEM-stage result
- wb_regwrite  in  1  WB-stage write enable
- wb_rd  in  REG_ADDR  WB-stage destination
- wb_result  in  DATA_WIDTH  WB-stage result
- ex_valid  out  1  EX stage holds a live instruction
- SrcA, SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation code
- ex_rd  out  REG_ADDR  destination index
- ex_regwrite, ex_memread, ex_memwrite  out  1  control bits, gated by ex_valid
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, used as store data

Behaviour:
- Reset (reset=0, asynchronous): every registered field clears to 0, so ex_valid=0, Operation=0 and ex_rd=0. Control outputs are 0 and SrcA/SrcB evaluate from the cleared register values.
- load_use = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2 & !id_alusrc) | (ex_rd==id_rs2 & id_memwrite)).
- id_ready = !hold & !load_use. It is combinational.
- Priority on each rising edge:
  1. flush: ex_valid<=0 and control bits cleared; overrides hold and load_use.
  2. hold: all registers keep their values.
  3. load_use: bubble inserted (ex_valid<=0, control bits cleared); the decode instruction is not consumed.
  4. id_valid: all id_* fields are captured and ex_valid<=1.
  5. Otherwise: ex_valid<=0.
- Forwarding is combinational from the registered rs1/rs2, with separate, identical logic for A (rs1) and B (rs2):
  - If mem_regwrite & mem_rd!=0 & mem_rd==rs, take mem_result.
  - Else if wb_regwrite & wb_rd!=0 & wb_rd==rs, take wb_result.
  - Else take the registered data.
  - MEM has priority over WB. Register x0 is never forwarded.
- SrcA = fwdA. SrcB = alusrc ? imm : fwdB. ex_store_data = fwdB.
- Latency: one cycle from an accepted decode handshake to the operands at the ALU. The load-use penalty is exactly one bubble cycle.
- Reset mid-stall drops the stalled instruction; decode must re-present it.

Optional Feature:
- Macro: EX_STATS_EN.
- When defined, two extra outputs are added:
  - stall_count (32 bits): increments every cycle load_use=1 and hold=0.
  - fwd_count (32 bits): increments once per cycle in which ex_valid=1 and either operand is forwarded.
- Both counters clear on reset and wrap modulo 2^32.
- When the macro is not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then capture id_rs1_data=5, id_imm=7, id_alusrc=1, id_operation=0010 -> next cycle ex_valid=1, SrcA=5, SrcB=7, Operation=0010.
- EX holds rs1=3; mem_regwrite=1, mem_rd=3, mem_result=0xAA; wb_regwrite=1, wb_rd=3, wb_result=0xBB -> SrcA=0xAA (MEM priority). Drop mem_regwrite -> SrcA=0xBB.
- EX holds rs1=0; wb_rd=0, wb_regwrite=1, wb_result=0xFF -> SrcA equals the registered rs1 data, not 0xFF.
- EX holds memread with ex_rd=4; decode presents id_rs1=4 -> id_ready=0 for one cycle, then ex_valid=0 (bubble), then the instruction is captured.
- flush=1 and hold=1 in the same cycle -> ex_valid=0 next cycle.
- With EX_STATS_EN defined: 3 load-use stalls -> stall_count=3.
- Assert reset during a hold -> ex_valid=0 immediately, asynchronously, without waiting for a clock edge.
